// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/interlock scoreboard.
package fwd_pkg;

    // Widest register address a shadow tag can hold; narrower addresses are zero-extended.
    localparam int MAX_AW = 8;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] dst;
        logic              regWrite;
        logic              isLoad;
    } fwdTag_t;

    function automatic int selW(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic isProducer(input fwdTag_t t);
        return t.valid && t.regWrite && (t.dst != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder: one source operand against shadow entries e[0..DEPTH-1], youngest wins.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = 2
) (
    input  logic                  reqValid,
    input  logic [REG_AW-1:0]     src,
    input  fwdTag_t [DEPTH-1:0]   ents,
    output logic                  hit,
    output logic [SEL_W-1:0]      sel,
    output logic                  loadHazard
);

    always_comb begin
        hit        = 1'b0;
        sel        = SEL_W'(FWD_RF);
        loadHazard = 1'b0;
        // Scan oldest to youngest so the lowest index overwrites older matches.
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (reqValid && isProducer(ents[j]) && (ents[j].dst == MAX_AW'(src))) begin
                hit        = 1'b1;
                sel        = SEL_W'(j + 1);
                loadHazard = ents[j].isLoad && ((j + 1) < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding select and load-use interlock unit; shadows ID/EX and DEPTH downstream stages.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 2,
    localparam int SEL_W    = selW(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      advance,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
    output logic [15:0]               stall_cnt
);

    function automatic logic [15:0] satInc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    fwdTag_t                  shadow [DEPTH+1];
    fwdTag_t [DEPTH-1:0]      matchEnts;
    fwdTag_t                  idTag_p0;
    logic [NUM_SRC-1:0]       hitV;
    logic [NUM_SRC-1:0]       hazV;
    logic [SEL_W-1:0]         selV [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] nextSel_p0;
    logic                     hazard;
    logic                     insertId;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            matchEnts[j] = shadow[j];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : gMatch
        fwd_match #(
            .REG_AW  (REG_AW),
            .DEPTH   (DEPTH),
            .LOAD_LAT(LOAD_LAT),
            .SEL_W   (SEL_W)
        ) uMatch (
            .reqValid  (id_valid & id_src_used[i]),
            .src       (id_src[i*REG_AW +: REG_AW]),
            .ents      (matchEnts),
            .hit       (hitV[i]),
            .sel       (selV[i]),
            .loadHazard(hazV[i])
        );
    end

    always_comb begin
        nextSel_p0 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            nextSel_p0[i*SEL_W +: SEL_W] = hitV[i] ? selV[i] : SEL_W'(FWD_RF);
        end
    end

    assign hazard   = |hazV;
    assign stall    = id_valid & ~flush & hazard;
    assign insertId = id_valid & ~stall & ~flush;

    always_comb begin
        idTag_p0          = '0;
        idTag_p0.valid    = 1'b1;
        idTag_p0.dst      = MAX_AW'(id_dst);
        idTag_p0.regWrite = id_regwrite;
        idTag_p0.isLoad   = id_is_load;
    end

    // ID -> ID/EX boundary: shadow shift, EX select register and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                shadow[k] <= '0;
            end
            ex_fwd_sel <= '0;
            stall_cnt  <= '0;
        end else if (advance) begin
            shadow[0] <= insertId ? idTag_p0 : '0;
            for (int k = 1; k <= DEPTH; k++) begin
                shadow[k] <= shadow[k-1];
            end
            ex_fwd_sel <= insertId ? nextSel_p0 : '0;
            if (stall) begin
                stall_cnt <= satInc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scoreboard bench for fwd_scoreboard with default parameters (DEPTH=2, LOAD_LAT=2).
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst;
    logic        id_regwrite;
    logic        id_is_load;
    logic        advance;
    logic        flush;
    logic        stall;
    logic [3:0]  ex_fwd_sel;
    logic [15:0] stall_cnt;

    int nCmp  = 0;
    int nFail = 0;
    logic [3:0] expQ [$];

    fwd_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src     (id_src),
        .id_src_used(id_src_used),
        .id_dst     (id_dst),
        .id_regwrite(id_regwrite),
        .id_is_load (id_is_load),
        .advance    (advance),
        .flush      (flush),
        .stall      (stall),
        .ex_fwd_sel (ex_fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive ID at negedge, check stall, queue the expected EX select, compare after the edge.
    task automatic step(input string tag, input int s0, s1, used, dst, rw, ld, vld, fl, adv,
                        input int e0, e1, expStall);
        logic [3:0] exp;
        @(negedge clk);
        id_valid    = vld[0];
        id_src      = {s1[4:0], s0[4:0]};
        id_src_used = used[1:0];
        id_dst      = dst[4:0];
        id_regwrite = rw[0];
        id_is_load  = ld[0];
        flush       = fl[0];
        advance     = adv[0];
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(expStall));
        expQ.push_back({e1[1:0], e0[1:0]});
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        check({tag, ".sel"}, 32'(ex_fwd_sel), 32'(exp));
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_src = '0; id_src_used = '0; id_dst = '0;
        id_regwrite = 1'b0; id_is_load = 1'b0; advance = 1'b0; flush = 1'b0;
        #12;
        check("rst.sel", 32'(ex_fwd_sel), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM forward: add r1,r2,r3 ; sub r2,r1,r3
        step("exmem.add", 2, 3, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step("exmem.sub", 1, 3, 3, 2, 1, 0, 1, 0, 1, 1, 0, 0);
        idle3();

        // Shadowing: add r1 ; or r1 ; and r4,r1,r1
        step("shad.add", 2, 3, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step("shad.or",  6, 7, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step("shad.and", 1, 1, 3, 4, 1, 0, 1, 0, 1, 1, 1, 0);
        idle3();

        // MEM/WB forward: add r1 ; or r5 ; and r4,r1,r1
        step("memwb.add", 2, 3, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step("memwb.or",  6, 7, 3, 5, 1, 0, 1, 0, 1, 0, 0, 0);
        step("memwb.and", 1, 1, 3, 4, 1, 0, 1, 0, 1, 2, 2, 0);
        idle3();

        // Load-use: lw r2 ; add r3,r2,r2 stalls once, then forwards from MEM/WB
        step("lu.lw",     8, 0, 1, 2, 1, 1, 1, 0, 1, 0, 0, 0);
        step("lu.stall",  2, 2, 3, 3, 1, 0, 1, 0, 1, 0, 0, 1);
        check("lu.cnt", 32'(stall_cnt), 32'd1);
        step("lu.add",    2, 2, 3, 3, 1, 0, 1, 0, 1, 2, 2, 0);
        idle3();

        // r0 producer/consumer and unused operands
        step("r0.lw",     8, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        step("r0.use",    0, 0, 3, 6, 1, 0, 1, 0, 1, 0, 0, 0);
        step("unused.lw", 8, 0, 1, 9, 1, 1, 1, 0, 1, 0, 0, 0);
        step("unused.rd", 9, 9, 0, 6, 1, 0, 1, 0, 1, 0, 0, 0);
        step("late.rd",   9, 9, 1, 6, 1, 0, 1, 0, 1, 2, 0, 0);
        idle3();

        // Flush beats a load-use hazard
        step("fl.lw",  8, 0, 1, 2, 1, 1, 1, 0, 1, 0, 0, 0);
        step("fl.add", 2, 2, 3, 3, 1, 0, 1, 1, 1, 0, 0, 0);
        check("fl.cnt", 32'(stall_cnt), 32'd1);
        idle3();

        // Freeze during a stall: add r8 ; lw r2,(r8) ; add r3,r2,r2 held 3 cycles
        step("fz.add",  2, 3, 3, 8, 1, 0, 1, 0, 1, 0, 0, 0);
        step("fz.lw",   8, 0, 1, 2, 1, 1, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("fz.hold", 2, 2, 3, 3, 1, 0, 1, 0, 0, 1, 0, 1);
        check("fz.cnt.hold", 32'(stall_cnt), 32'd1);
        step("fz.stall", 2, 2, 3, 3, 1, 0, 1, 0, 1, 0, 0, 1);
        check("fz.cnt", 32'(stall_cnt), 32'd2);
        step("fz.add2",  2, 2, 3, 3, 1, 0, 1, 0, 1, 2, 2, 0);
        idle3();

        // Asynchronous reset in the middle of a stall
        step("mr.add", 2, 3, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0);
        step("mr.lw",  1, 0, 1, 2, 1, 1, 1, 0, 1, 1, 0, 0);
        @(negedge clk);
        id_valid = 1'b1; id_src = {5'd2, 5'd2}; id_src_used = 2'b11; id_dst = 5'd3;
        id_regwrite = 1'b1; id_is_load = 1'b0; flush = 1'b0; advance = 1'b1;
        #1;
        check("mr.stall.pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr.stall", 32'(stall), 32'd0);
        check("mr.sel", 32'(ex_fwd_sel), 32'd0);
        check("mr.cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mr.first", 1, 0, 1, 4, 1, 0, 1, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and interlock unit that replaces the combinational EX-stage forwarding mux select. It keeps its own shadow of destination/write/load tags for the pipeline registers from ID/EX through DEPTH stages downstream. It resolves forwarding for every source operand of the instruction in ID and registers the selects into EX on advance. It also detects load-use hazards, inserts bubbles and counts stall cycles.

## Interface
- REG_AW, 5: register-address width.
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 2: forwardable pipeline registers after ID/EX (1 = EX/MEM, 2 = MEM/WB, …), 1..7.
- LOAD_LAT, 2: first tracked stage whose register holds load data, 1..DEPTH.
- SEL_W, clog2(DEPTH+1): select width (derived, not overridable).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction present in ID.
- id_src  in  NUM_SRC*REG_AW  source register numbers, operand i at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_dst  in  REG_AW  destination (rd or rt, already muxed).
- id_regwrite  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a load.
- advance  in  1  pipeline moves this cycle (0 = global freeze).
- flush  in  1  kill the ID instruction (branch/jump redirect).
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-operand select for EX: 0 = register file, k = tracked stage k.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Shadow entries e[0..DEPTH]: {valid, dst, regwrite, is_load}. e[0] mirrors ID/EX, e[k] mirrors stage k.
- An entry is a producer iff valid & regwrite & dst != 0.
- Match for operand i: id_valid & id_src_used[i] & producer e[j] with e[j].dst == id_src[i], for j in 0..DEPTH-1.
- The youngest match (lowest j) wins, so later writers shadow older ones. No match, or src == 0 → 0.
- Next select for operand i = j+1, because the producer moves one stage when the consumer enters EX. A match only in e[DEPTH] retires before the consumer reaches EX and gives 0; the register file write-before-read rule covers it.
- Hazard: the winning match for any operand has is_load = 1 and j+1 < LOAD_LAT.
- stall = id_valid & ~flush & hazard. Combinational, independent of advance.
- On advance = 1:
  - e[k] ← e[k-1] for k = 1..DEPTH; old e[DEPTH] is dropped.
  - e[0] ← the ID tag if id_valid & ~stall & ~flush, else a bubble (valid = 0).
  - ex_fwd_sel ← the computed selects, or all zero when a bubble is inserted.
- On advance = 0: entries, ex_fwd_sel and stall_cnt hold.
- stall_cnt increments on every cycle with stall & advance and saturates at 16'hFFFF.
- flush and stall together: flush wins. No stall is raised and a bubble enters.
- With LOAD_LAT = 1 the hazard term is constant 0, so the unit never stalls.

## Timing
- Reset (asynchronous, immediate):
  - all entries are invalid.
  - ex_fwd_sel = 0.
  - stall_cnt = 0.
  - stall = 0, because there are no valid producers.
- ex_fwd_sel latency: 1 cycle. It is valid for the instruction sitting in ID/EX and refers to stage contents in that same cycle.
- stall asserts in the same cycle that a dependent instruction is in ID. It stays high while the hazard persists: LOAD_LAT−(j+1) advancing cycles, 1 for the default parameters.
- Deasserting rst_n mid-stall clears stall in the same cycle. The first advancing edge after release sees an empty shadow.

## Structure
- Package fwd_pkg holds:
  - the tag struct {valid, dst, regwrite, is_load}.
  - the SEL_W function.
  - the encodings FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2.
- Sub-module fwd_match: one operand against e[0..DEPTH-1]. It is a priority encoder that outputs {hit, sel, load_hazard}.
- fwd_scoreboard instantiates fwd_match NUM_SRC times in a generate loop and holds the shift register, select register and counter.

## Test plan
- Reset behaviour: hold rst_n = 0 mid-run → ex_fwd_sel = 0, stall = 0 and stall_cnt = 0 immediately. The first post-reset instruction reading r1 gets select 0.
- EX/MEM forward: issue add r1 then sub r2,r1,r3 back-to-back with advance = 1 → for the sub in EX, operand 0 select = 1 and operand 1 select = 0.
- MEM/WB forward and shadowing: issue add r1; or r1; and r4,r1,r1.
  - Consumer sees select 1 on both operands (youngest producer).
  - Replace the second instruction with one writing r5 → select 2 on both operands.
- Load-use stall: issue lw r2 then add r3,r2,r2 (DEPTH = 2, LOAD_LAT = 2).
  - stall = 1 for exactly 1 cycle, a bubble enters ID/EX and stall_cnt = 1.
  - Then add in EX with both selects = 2.
- r0 and unused operands: a producer writes r0 and the consumer reads r0; also id_src_used = 0 on a match → selects 0 and no stall, even when the producer is a load.
- Flush and freeze:
  - flush together with a load-use hazard → stall = 0 and a bubble enters.
  - advance = 0 for 3 cycles during a stall → entries, ex_fwd_sel and stall_cnt unchanged, stall held high.
